// File: rtl/drum_pkg.sv
// Shared geometry defaults, derived widths and the sector-address decode for the drum store.
// Modules size themselves from their own parameters; these values are the default build.
package drum_pkg;

  localparam int DEF_TRACKS = 32;
  localparam int DEF_WORDS  = 128;
  localparam int DEF_BITS   = 40;
  localparam int DEF_HEADS  = 2;
  localparam int DEF_WOFF   = 320;

  localparam int CELLS = DEF_WORDS * DEF_BITS;
  localparam int TW    = $clog2(DEF_TRACKS);
  localparam int AW    = $clog2(DEF_WORDS);
  localparam int PW    = $clog2(CELLS);

  // Serial sector address: word index LSB first in the AW slots before the word mark,
  // then a "word zero" flag in the mark slot itself.
  function automatic logic zs_bit(input int unsigned w, input int unsigned s,
                                  input int unsigned aw, input int unsigned bits);
    int unsigned base;
    base = bits - aw - 1;
    if (s == bits - 1) return (w == 0);
    if (s >= base) return ((w >> (s - base)) & 1) != 0;
    return 1'b0;
  endfunction

endpackage

// File: rtl/drum_multihead_store_if.sv
// Head and timing-mark signal bundle between the drum store and its sequencer.
interface drum_multihead_store_if #(
  parameter int N_HEADS = drum_pkg::DEF_HEADS,
  parameter int TRK_W   = drum_pkg::TW,
  parameter int POS_W   = drum_pkg::PW
);
  logic [N_HEADS*TRK_W-1:0] TRK;
  logic [N_HEADS-1:0]       A;
  logic [N_HEADS-1:0]       B;
  logic [N_HEADS-1:0]       W1;
  logic [N_HEADS-1:0]       R;
  logic [POS_W-1:0]         POS;
  logic                     WMARK;
  logic                     INDEX;
  logic                     ZS;
  logic                     FAULT;

  modport master (output TRK, A, B, W1, input R, POS, WMARK, INDEX, ZS, FAULT);
  modport slave  (input TRK, A, B, W1, output R, POS, WMARK, INDEX, ZS, FAULT);
endinterface

// File: rtl/drum_timing_gen.sv
// Angular position counter plus registered timing marks (word mark, index, sector address)
// and the write-head position, which leads the read head by WOFF cells.
module drum_timing_gen import drum_pkg::*; #(
  parameter  int WORDS   = DEF_WORDS,
  parameter  int BITS    = DEF_BITS,
  parameter  int WOFF    = DEF_WOFF,
  localparam int N_CELLS = WORDS * BITS,
  localparam int POS_W   = $clog2(N_CELLS),
  localparam int ADR_W   = $clog2(WORDS),
  localparam int SLOT_W  = $clog2(BITS)
) (
  input  logic             Z1,
  input  logic             RST,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] wp,
  output logic             wmark,
  output logic             index,
  output logic             zs
);

  logic [POS_W-1:0]  pos_n, wp_n;
  logic [SLOT_W-1:0] slot, slot_n;
  logic [ADR_W-1:0]  word, word_n;

  // NOTE: combinational next-state uses blocking '=' with every output defaulted first,
  // so no latch can be inferred; the state register below uses '<=' only.
  always_comb begin
    pos_n  = pos;
    wp_n   = wp;
    slot_n = slot;
    word_n = word;
    pos_n  = (pos == POS_W'(N_CELLS - 1)) ? '0 : pos + POS_W'(1);
    wp_n   = (wp  == POS_W'(N_CELLS - 1)) ? '0 : wp  + POS_W'(1);
    if (slot == SLOT_W'(BITS - 1)) begin
      slot_n = '0;
      word_n = (word == ADR_W'(WORDS - 1)) ? '0 : word + ADR_W'(1);
    end else begin
      slot_n = slot + SLOT_W'(1);
    end
  end

  // Marks are decoded from the next position so they stay aligned with the registered POS.
  always_ff @(posedge Z1) begin
    if (RST) begin
      pos   <= '0;
      wp    <= POS_W'(WOFF);
      slot  <= '0;
      word  <= '0;
      wmark <= 1'b0;
      index <= 1'b1;
      zs    <= 1'b0;
    end else begin
      pos   <= pos_n;
      wp    <= wp_n;
      slot  <= slot_n;
      word  <= word_n;
      wmark <= (slot_n == SLOT_W'(BITS - 1));
      index <= (pos_n == '0);
      zs    <= zs_bit(int'(word_n), int'(slot_n), ADR_W, BITS);
    end
  end

endmodule

// File: rtl/drum_multihead_store.sv
// Rotating serial store: TRACKS tracks of WORDS*BITS cells served by HEADS independent
// read/write heads, with drum timing marks generated alongside.
module drum_multihead_store import drum_pkg::*; #(
  parameter  int TRACKS  = DEF_TRACKS,
  parameter  int WORDS   = DEF_WORDS,
  parameter  int BITS    = DEF_BITS,
  parameter  int HEADS   = DEF_HEADS,
  parameter  int WOFF    = DEF_WOFF,
  localparam int N_CELLS = WORDS * BITS,
  localparam int TRK_W   = $clog2(TRACKS),
  localparam int POS_W   = $clog2(N_CELLS)
) (
  input logic Z1,
  input logic RST,
  drum_multihead_store_if.slave bus
);

  logic [POS_W-1:0] pos, wp;
  logic             wmark, index, zs;
  logic [TRK_W-1:0] trk_sel [HEADS];
  logic [HEADS-1:0] wr_en, illegal;
  logic [HEADS-1:0] r_q;
  logic             fault_q;

  // NOTE: the cell array has no reset; drum contents persist across RST by design.
  logic mem [TRACKS][N_CELLS];

  drum_timing_gen #(.WORDS(WORDS), .BITS(BITS), .WOFF(WOFF)) u_timing (
    .Z1   (Z1),
    .RST  (RST),
    .pos  (pos),
    .wp   (wp),
    .wmark(wmark),
    .index(index),
    .zs   (zs)
  );

  for (genvar h = 0; h < HEADS; h++) begin : g_head
    assign trk_sel[h] = bus.TRK[h*TRK_W +: TRK_W];
    assign wr_en[h]   = bus.W1[h] & (bus.A[h] ^ bus.B[h]);
    assign illegal[h] = bus.W1[h] & bus.A[h] & bus.B[h];
  end

  // Ascending head order: a later head's write to the same cell overrides an earlier one.
  always_ff @(posedge Z1) begin
    if (!RST) begin
      for (int h = 0; h < HEADS; h++) begin
        if (wr_en[h]) mem[trk_sel[h]][wp] <= bus.A[h];
      end
    end
  end

  // Reads sample the array before this edge's writes land, so a same-cell hit returns old data.
  always_ff @(posedge Z1) begin
    if (RST) begin
      r_q     <= '0;
      fault_q <= 1'b0;
    end else begin
      for (int h = 0; h < HEADS; h++) r_q[h] <= mem[trk_sel[h]][pos];
      if (|illegal) fault_q <= 1'b1;
    end
  end

  assign bus.R     = r_q;
  assign bus.POS   = pos;
  assign bus.WMARK = wmark;
  assign bus.INDEX = index;
  assign bus.ZS    = zs;
  assign bus.FAULT = fault_q;

endmodule

// File: tb/tb_drum_multihead_store.sv
// Self-checking bench for drum_multihead_store: timing marks, per-head writes, head priority,
// illegal-pair fault and mid-revolution reset, with read expectations held in a scoreboard.
module tb_drum_multihead_store;
  import drum_pkg::*;

  typedef struct {
    int   pos;
    int   head;
    logic val;
  } exp_t;

  logic Z1 = 1'b0;
  logic RST = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  drum_multihead_store_if #(.N_HEADS(DEF_HEADS), .TRK_W(TW), .POS_W(PW)) bus ();

  drum_multihead_store #(
    .TRACKS(DEF_TRACKS), .WORDS(DEF_WORDS), .BITS(DEF_BITS), .HEADS(DEF_HEADS), .WOFF(DEF_WOFF)
  ) dut (
    .Z1 (Z1),
    .RST(RST),
    .bus(bus)
  );

  always #5 Z1 = ~Z1;

  task automatic tick();
    @(posedge Z1);
    #1;
  endtask

  task automatic idle();
    bus.W1 = '0;
    bus.A  = '0;
    bus.B  = '0;
  endtask

  task automatic set_trk(input int h, input int t);
    bus.TRK[h*TW +: TW] = TW'(t);
  endtask

  task automatic wait_pos(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * CELLS; i++) begin
      if (int'(bus.POS) == target) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_pos: POS=%0d never reached %0d", bus.POS, target);
    end
  endtask

  // R observed after an edge holds the cell addressed at that edge, i.e. POS-1.
  function automatic int read_cell();
    return (int'(bus.POS) + CELLS - 1) % CELLS;
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    idle();
    bus.TRK = '0;
    repeat (3) tick();
    n_cmp++; if (bus.POS !== '0)     begin n_bad++; $display("FAIL reset_pos: got %0d want 0", bus.POS); end
    n_cmp++; if (bus.R !== '0)       begin n_bad++; $display("FAIL reset_r: got %b want 00", bus.R); end
    n_cmp++; if (bus.FAULT !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", bus.FAULT); end
    n_cmp++; if (bus.INDEX !== 1'b1) begin n_bad++; $display("FAIL reset_index: got %b want 1", bus.INDEX); end
    n_cmp++; if (bus.WMARK !== 1'b0) begin n_bad++; $display("FAIL reset_wmark: got %b want 0", bus.WMARK); end
    n_cmp++; if (bus.ZS !== 1'b0)    begin n_bad++; $display("FAIL reset_zs: got %b want 0", bus.ZS); end
  endtask

  task automatic test_revolution();
    int idx_cnt, wm_cnt, pos_err, zs_err, wm_err;
    int p, w, s;
    logic exp_zs;
    RST = 1'b0;
    idx_cnt = (bus.INDEX === 1'b1) ? 1 : 0;
    wm_cnt = 0; pos_err = 0; zs_err = 0; wm_err = 0;
    for (int i = 1; i <= CELLS; i++) begin
      tick();
      p = i % CELLS;
      w = p / DEF_BITS;
      s = p % DEF_BITS;
      if (s == DEF_BITS - 1)            exp_zs = (w == 0);
      else if (s >= DEF_BITS - AW - 1)  exp_zs = w[s - (DEF_BITS - AW - 1)];
      else                              exp_zs = 1'b0;
      if (bus.POS !== PW'(p))                     pos_err++;
      if (bus.ZS !== exp_zs)                      zs_err++;
      if (bus.WMARK !== (s == DEF_BITS - 1))      wm_err++;
      if (bus.INDEX === 1'b1) idx_cnt++;
      if (bus.WMARK === 1'b1) wm_cnt++;
    end
    n_cmp++; if (bus.POS !== '0) begin n_bad++; $display("FAIL rev_wrap: POS=%0d want 0", bus.POS); end
    n_cmp++; if (pos_err != 0)   begin n_bad++; $display("FAIL rev_pos_seq: %0d cycles off, want 0", pos_err); end
    n_cmp++; if (zs_err != 0)    begin n_bad++; $display("FAIL rev_zs_seq: %0d cycles off, want 0", zs_err); end
    n_cmp++; if (wm_err != 0)    begin n_bad++; $display("FAIL rev_wmark_seq: %0d cycles off, want 0", wm_err); end
    n_cmp++; if (idx_cnt != 2)   begin n_bad++; $display("FAIL rev_index_count: got %0d want 2", idx_cnt); end
    n_cmp++; if (wm_cnt != DEF_WORDS) begin n_bad++; $display("FAIL rev_wmark_count: got %0d want %0d", wm_cnt, DEF_WORDS); end
  endtask

  task automatic test_zs_sector();
    logic zs_w5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int budget;
    for (int k = 0; k < 8; k++) sb.push_back('{pos: 5 * DEF_BITS + 32 + k, head: 0, val: zs_w5[k]});
    sb.push_back('{pos: DEF_BITS - 1, head: 0, val: 1'b1});
    budget = 2 * CELLS;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
      if (int'(bus.POS) == sb[0].pos) begin
        n_cmp++;
        if (bus.ZS !== sb[0].val) begin
          n_bad++;
          $display("FAIL zs_slot pos=%0d: got %b want %b", sb[0].pos, bus.ZS, sb[0].val);
        end
        void'(sb.pop_front());
      end
    end
    while (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL zs_timeout pos=%0d: not observed", sb[0].pos);
      void'(sb.pop_front());
    end
  endtask

  // Writes zero over every cell of the tracks used below so expectations do not depend on power-up.
  task automatic clear_tracks();
    set_trk(0, 3);
    set_trk(1, 7);
    bus.W1 = 2'b11;
    bus.A  = 2'b00;
    bus.B  = 2'b11;
    repeat (CELLS) tick();
    idle();
  endtask

  task automatic test_write_single();
    int budget, c;
    set_trk(0, 3);
    wait_pos(100);
    bus.W1[0] = 1'b1; bus.A[0] = 1'b1; bus.B[0] = 1'b0;
    tick();
    idle();
    for (int k = 418; k <= 422; k++) sb.push_back('{pos: k, head: 0, val: (k == 100 + DEF_WOFF)});
    budget = 2 * CELLS;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
      c = read_cell();
      while (sb.size() > 0 && sb[0].pos == c) begin
        n_cmp++;
        if (bus.R[sb[0].head] !== sb[0].val) begin
          n_bad++;
          $display("FAIL write_single cell=%0d head=%0d: got %b want %b", c, sb[0].head, bus.R[sb[0].head], sb[0].val);
        end
        void'(sb.pop_front());
      end
    end
    while (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL write_single_timeout cell=%0d: not read", sb[0].pos);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_two_heads();
    int budget, c;
    set_trk(0, 7);
    set_trk(1, 7);
    wait_pos(1000);
    bus.W1 = 2'b11;
    bus.A  = 2'b10;
    bus.B  = 2'b01;
    tick();
    idle();
    sb.push_back('{pos: 1000 + DEF_WOFF, head: 0, val: 1'b1});
    sb.push_back('{pos: 1000 + DEF_WOFF, head: 1, val: 1'b1});
    budget = 2 * CELLS;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
      c = read_cell();
      while (sb.size() > 0 && sb[0].pos == c) begin
        n_cmp++;
        if (bus.R[sb[0].head] !== sb[0].val) begin
          n_bad++;
          $display("FAIL two_heads cell=%0d head=%0d: got %b want %b", c, sb[0].head, bus.R[sb[0].head], sb[0].val);
        end
        void'(sb.pop_front());
      end
    end
    while (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL two_heads_timeout cell=%0d: not read", sb[0].pos);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_fault();
    int budget, c;
    set_trk(0, 3);
    wait_pos(2500);
    n_cmp++; if (bus.FAULT !== 1'b0) begin n_bad++; $display("FAIL fault_pre: got %b want 0", bus.FAULT); end
    bus.W1[0] = 1'b1; bus.A[0] = 1'b1; bus.B[0] = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.FAULT !== 1'b1) begin n_bad++; $display("FAIL fault_set: got %b want 1", bus.FAULT); end
    repeat (5) tick();
    n_cmp++; if (bus.FAULT !== 1'b1) begin n_bad++; $display("FAIL fault_hold: got %b want 1", bus.FAULT); end
    sb.push_back('{pos: 2500 + DEF_WOFF, head: 0, val: 1'b0});
    budget = 2 * CELLS;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
      c = read_cell();
      while (sb.size() > 0 && sb[0].pos == c) begin
        n_cmp++;
        if (bus.R[sb[0].head] !== sb[0].val) begin
          n_bad++;
          $display("FAIL fault_nowrite cell=%0d: got %b want %b", c, bus.R[sb[0].head], sb[0].val);
        end
        void'(sb.pop_front());
      end
    end
    while (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL fault_timeout cell=%0d: not read", sb[0].pos);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    int budget, c;
    set_trk(0, 3);
    set_trk(1, 7);
    wait_pos(1679);
    bus.W1[0] = 1'b1; bus.A[0] = 1'b1; bus.B[0] = 1'b0;
    tick();
    idle();
    wait_pos(2000);
    n_cmp++; if (bus.R[0] !== 1'b1)  begin n_bad++; $display("FAIL rst_pre_r: got %b want 1", bus.R[0]); end
    n_cmp++; if (bus.FAULT !== 1'b1) begin n_bad++; $display("FAIL rst_pre_fault: got %b want 1", bus.FAULT); end
    RST = 1'b1;
    bus.W1[1] = 1'b1; bus.A[1] = 1'b1; bus.B[1] = 1'b0;
    tick();
    RST = 1'b0;
    idle();
    n_cmp++; if (bus.POS !== '0)     begin n_bad++; $display("FAIL rst_pos: got %0d want 0", bus.POS); end
    n_cmp++; if (bus.R !== '0)       begin n_bad++; $display("FAIL rst_r: got %b want 00", bus.R); end
    n_cmp++; if (bus.FAULT !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", bus.FAULT); end
    n_cmp++; if (bus.INDEX !== 1'b1) begin n_bad++; $display("FAIL rst_index: got %b want 1", bus.INDEX); end
    sb.push_back('{pos: 420,  head: 0, val: 1'b1});
    sb.push_back('{pos: 1320, head: 1, val: 1'b1});
    sb.push_back('{pos: 1999, head: 0, val: 1'b1});
    sb.push_back('{pos: 2000 + DEF_WOFF, head: 1, val: 1'b0});
    budget = 2 * CELLS;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
      c = read_cell();
      while (sb.size() > 0 && sb[0].pos == c) begin
        n_cmp++;
        if (bus.R[sb[0].head] !== sb[0].val) begin
          n_bad++;
          $display("FAIL rst_persist cell=%0d head=%0d: got %b want %b", c, sb[0].head, bus.R[sb[0].head], sb[0].val);
        end
        void'(sb.pop_front());
      end
    end
    while (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rst_persist_timeout cell=%0d: not read", sb[0].pos);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_revolution();
    test_zs_sector();
    clear_tracks();
    test_write_single();
    test_two_heads();
    test_fault();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
